// File: rtl/posit_normalize_pkg.sv
// Shared posit helpers: field-width functions, special encodings and the
// largest representable scale. Imported by the posit_normalize block.
package posit_defines;

  function automatic int get_scale_width(input int n, input int es, input int extra);
    return $clog2(n - 1) + es + 1 + extra;
  endfunction

  function automatic int get_fraction_width(input int n, input int es, input int extra);
    return n - 3 - es + extra;
  endfunction

  // (N-2)*2^ES: scale of maxpos; its negation is the scale of minpos
  function automatic int posit_max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 0) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/posit_normalize_round.sv
// posit_round: round-to-nearest-even on a truncated posit magnitude.
// o_carry flags a round-up that wrapped past the all-ones magnitude.
module posit_round #(
  parameter int MAG_WIDTH = 7
) (
  input  logic [MAG_WIDTH-1:0] i_mag,
  input  logic                 i_guard,
  input  logic                 i_sticky,
  output logic [MAG_WIDTH-1:0] o_mag,
  output logic                 o_carry
);

  logic w_inc;

  assign w_inc = i_guard & (i_mag[0] | i_sticky);
  assign {o_carry, o_mag} = {1'b0, i_mag} + {{MAG_WIDTH{1'b0}}, w_inc};

endmodule

// File: rtl/posit_normalize.sv
// posit_normalize: 3-stage posit encoder with saturation and a shared stall
// enable. Defining POSIT_NORMALIZE_RNE_EN selects RNE, otherwise truncation.
module posit_normalize
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH    = 8,
  parameter int POSIT_ES       = 1,
  parameter int SCALE_WIDTH    = get_scale_width(POSIT_WIDTH, POSIT_ES, 0),
  parameter int FRACTION_WIDTH = get_fraction_width(POSIT_WIDTH, POSIT_ES, 0)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          sign_i,
  input  logic                          NaR_i,
  input  logic                          zero_i,
  input  logic signed [SCALE_WIDTH-1:0] scale_i,
  input  logic [FRACTION_WIDTH-1:0]     fraction_i,
  input  logic                          sticky_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [POSIT_WIDTH-1:0]        posit_word_o
);

  localparam int MW  = POSIT_WIDTH - 1;
  localparam int EFW = POSIT_ES + FRACTION_WIDTH;
  localparam int BW  = EFW + POSIT_WIDTH;
  localparam logic signed [SCALE_WIDTH-1:0] MAX_SCALE =
    SCALE_WIDTH'(posit_max_scale(POSIT_WIDTH, POSIT_ES));
  localparam logic signed [SCALE_WIDTH-1:0] MIN_SCALE =
    SCALE_WIDTH'(-posit_max_scale(POSIT_WIDTH, POSIT_ES));
  localparam logic [POSIT_WIDTH-1:0] MAXPOS = POSIT_WIDTH'(posit_maxpos(POSIT_WIDTH));
  localparam logic [POSIT_WIDTH-1:0] MINPOS = POSIT_WIDTH'(posit_minpos(POSIT_WIDTH));
  localparam logic [POSIT_WIDTH-1:0] NAR    = POSIT_WIDTH'(posit_nar(POSIT_WIDTH));

  logic                          w_adv;
  logic signed [SCALE_WIDTH-1:0] w_k;
  logic [EFW-1:0]                w_ef;
  logic                          w_ovf;
  logic                          w_unf;

  logic                          r_s1_valid;
  logic                          r_s1_sign;
  logic                          r_s1_nar;
  logic                          r_s1_zero;
  logic                          r_s1_ovf;
  logic                          r_s1_unf;
  logic signed [SCALE_WIDTH-1:0] r_s1_k;
  logic [EFW-1:0]                r_s1_ef;

  logic                          w_kneg;
  logic [SCALE_WIDTH-1:0]        w_shamt;
  logic [BW-1:0]                 w_seed;
  logic [BW-1:0]                 w_buf;
  logic [MW-1:0]                 w_mag_trunc;
  logic [MW-1:0]                 w_mag_rnd;
  logic                          w_carry;

  logic                          r_s2_valid;
  logic                          r_s2_sign;
  logic                          r_s2_nar;
  logic                          r_s2_zero;
  logic                          r_s2_ovf;
  logic                          r_s2_unf;
  logic [MW-1:0]                 r_s2_mag;

  logic [POSIT_WIDTH-1:0]        w_pos;
  logic [POSIT_WIDTH-1:0]        w_word;
  logic                          r_s3_valid;
  logic [POSIT_WIDTH-1:0]        r_word;

  // One enable for every stage: the pipe moves unless the output is stalled
  assign w_adv     = out_ready | ~r_s3_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_valid;
  assign posit_word_o = r_word;

  assign w_k   = scale_i >>> POSIT_ES;
  assign w_ovf = (scale_i > MAX_SCALE);
  assign w_unf = (scale_i < MIN_SCALE);

  generate
    if (POSIT_ES > 0) begin : g_es
      assign w_ef = {scale_i[POSIT_ES-1:0], fraction_i};
    end else begin : g_no_es
      assign w_ef = fraction_i;
    end
  endgenerate

  // Stage 1: split scale into regime count and exponent, flag out-of-range
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_unf   <= 1'b0;
      r_s1_k     <= {SCALE_WIDTH{1'b0}};
      r_s1_ef    <= {EFW{1'b0}};
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= sign_i;
      r_s1_nar   <= NaR_i;
      r_s1_zero  <= zero_i;
      r_s1_ovf   <= w_ovf;
      r_s1_unf   <= w_unf;
      r_s1_k     <= w_k;
      r_s1_ef    <= w_ef;
    end
  end

  // Seed "10" (k>=0) or "01" (k<0) ahead of e/fraction; sign-filling shift
  // by k or ~k grows the run to k+1 ones or -k zeros with no bits lost.
  assign w_kneg      = r_s1_k[SCALE_WIDTH-1];
  assign w_shamt     = w_kneg ? ~r_s1_k : r_s1_k;
  assign w_seed      = {~w_kneg, w_kneg, r_s1_ef, {(POSIT_WIDTH-2){1'b0}}};
  assign w_buf       = $signed(w_seed) >>> w_shamt;
  assign w_mag_trunc = w_buf[BW-1 -: MW];

`ifdef POSIT_NORMALIZE_RNE_EN
  logic r_s1_sticky;
  logic w_guard;
  logic w_sticky;

  // Incoming sticky travels alongside stage 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_sticky <= 1'b0;
    end else if (w_adv) begin
      r_s1_sticky <= sticky_i;
    end
  end

  assign w_guard  = w_buf[BW-POSIT_WIDTH];
  assign w_sticky = (|w_buf[BW-POSIT_WIDTH-1:0]) | r_s1_sticky;

  posit_round #(
    .MAG_WIDTH(MW)
  ) u_round (
    .i_mag   (w_mag_trunc),
    .i_guard (w_guard),
    .i_sticky(w_sticky),
    .o_mag   (w_mag_rnd),
    .o_carry (w_carry)
  );
`else
  logic w_unused_tail;

  assign w_unused_tail = ^{w_buf[BW-POSIT_WIDTH:0], sticky_i};
  assign w_mag_rnd     = w_mag_trunc;
  assign w_carry       = 1'b0;
`endif

  // Stage 2: rounded magnitude; a rounding carry counts as overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_nar   <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_unf   <= 1'b0;
      r_s2_mag   <= {MW{1'b0}};
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_nar   <= r_s1_nar;
      r_s2_zero  <= r_s1_zero;
      r_s2_ovf   <= r_s1_ovf | w_carry;
      r_s2_unf   <= r_s1_unf;
      r_s2_mag   <= w_mag_rnd;
    end
  end

  // Specials first, then saturation, then sign applied to any finite result
  always_comb begin
    w_pos  = {POSIT_WIDTH{1'b0}};
    w_word = {POSIT_WIDTH{1'b0}};
    if (r_s2_nar) begin
      w_word = NAR;
    end else if (r_s2_zero) begin
      w_word = {POSIT_WIDTH{1'b0}};
    end else begin
      if (r_s2_ovf) begin
        w_pos = MAXPOS;
      end else if (r_s2_unf || (r_s2_mag == {MW{1'b0}})) begin
        w_pos = MINPOS;
      end else begin
        w_pos = {1'b0, r_s2_mag};
      end
      if (r_s2_sign) begin
        w_word = (~w_pos) + POSIT_WIDTH'(1);
      end else begin
        w_word = w_pos;
      end
    end
  end

  // Stage 3: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_word     <= {POSIT_WIDTH{1'b0}};
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      r_word     <= w_word;
    end
  end

endmodule

// File: tb/tb_posit_normalize.sv
// Directed bench for posit_normalize (N=8, ES=1); rounding expectations
// follow POSIT_NORMALIZE_RNE_EN.
module tb_posit_normalize;

  typedef struct packed {
    logic       sign;
    logic       nar;
    logic       zero;
    logic [4:0] scale;
    logic [3:0] frac;
    logic       sticky;
    logic [7:0] exp;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              sign_i;
  logic              nar_i;
  logic              zero_i;
  logic signed [4:0] scale_i;
  logic [3:0]        fraction_i;
  logic              sticky_i;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        posit_word_o;

  int n_cmp;
  int n_fail;

  beat_t      stim_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         in_cyc[$];
  logic       timed_out;
  int         stall_viol;
  int         stall_seen;
  int         extra;

  posit_normalize #(
    .POSIT_WIDTH(8),
    .POSIT_ES   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_i      (sign_i),
    .NaR_i       (nar_i),
    .zero_i      (zero_i),
    .scale_i     (scale_i),
    .fraction_i  (fraction_i),
    .sticky_i    (sticky_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .posit_word_o(posit_word_o)
  );

  always #5 clk = ~clk;

  task automatic apply(input beat_t b);
    sign_i     = b.sign;
    nar_i      = b.nar;
    zero_i     = b.zero;
    scale_i    = b.scale;
    fraction_i = b.frac;
    sticky_i   = b.sticky;
  endtask

  task automatic add(input logic s, input logic n, input logic z, input int sc,
                     input logic [3:0] f, input logic st, input logic [7:0] e);
    beat_t b;
    b.sign = s; b.nar = n; b.zero = z; b.scale = 5'(sc);
    b.frac = f; b.sticky = st; b.exp = e;
    stim_q.push_back(b);
  endtask

  // Drives stim_q with out_ready low in cycles [stall_lo, stall_hi]; records outputs.
  task automatic run_beats(input int stall_lo, input int stall_hi, input int budget);
    int idx;
    int n;
    int rel;
    idx = 0; n = stim_q.size(); rel = 0;
    got_q.delete(); got_cyc.delete(); in_cyc.delete();
    timed_out = 1'b0; stall_viol = 0; stall_seen = 0; extra = 0;
    while ((got_q.size() < n) && !timed_out) begin
      if (rel >= budget) begin
        timed_out = 1'b1;
      end else begin
        out_ready = !((rel >= stall_lo) && (rel <= stall_hi));
        if (idx < n) begin
          in_valid = 1'b1;
          apply(stim_q[idx]);
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        if (out_valid && !out_ready) begin
          stall_seen++;
          if (in_ready) stall_viol++;
        end
        if (out_valid && out_ready) begin
          got_q.push_back(posit_word_o);
          got_cyc.push_back(rel);
        end
        if (in_valid && in_ready) begin
          in_cyc.push_back(rel);
          idx++;
        end
        @(posedge clk); #1;
        rel++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
  endtask

  // Posit decoder for N=8, ES=1 producing the encoder's input fields.
  function automatic beat_t decode(input logic [7:0] w);
    beat_t      b;
    logic [7:0] mag;
    logic [6:0] body;
    logic [6:0] tail;
    logic       r;
    logic       run;
    int         m;
    int         k;
    b = '0;
    b.exp = w;
    if (w == 8'h00) begin
      b.zero = 1'b1;
    end else if (w == 8'h80) begin
      b.nar = 1'b1;
    end else begin
      b.sign = w[7];
      mag  = w[7] ? (8'h00 - w) : w;
      body = mag[6:0];
      r = body[6]; run = 1'b1; m = 0;
      for (int i = 6; i >= 0; i--) begin
        if (run && (body[i] == r)) m++;
        else run = 1'b0;
      end
      k = r ? (m - 1) : -m;
      tail = body << (m + 1);
      b.scale = 5'(k * 2 + int'(tail[6]));
      b.frac  = tail[5:2];
    end
    return b;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; scale_i = 5'sd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (posit_word_o !== 8'h00) begin n_fail++; $display("FAIL reset_word: got 0x%02h want 0x00", posit_word_o); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_basic;
    stim_q.delete();
    add(1'b0, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 8'h40);
    add(1'b0, 1'b0, 1'b0, 1, 4'b0000, 1'b0, 8'h50);
    add(1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 8'h60);
    add(1'b0, 1'b0, 1'b0, 0, 4'b1000, 1'b0, 8'h48);
    add(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 8'hC0);
    run_beats(-1, -1, 40);
    n_cmp++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d want 5", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== stim_q[j].exp) begin
        n_fail++; $display("FAIL basic_word[%0d]: got 0x%02h want 0x%02h", j, got_q[j], stim_q[j].exp);
      end
      n_cmp++;
      if ((got_cyc[j] - in_cyc[j]) !== 3) begin
        n_fail++; $display("FAIL basic_latency[%0d]: got %0d want 3", j, got_cyc[j] - in_cyc[j]);
      end
    end
  endtask

  task automatic test_rounding;
    stim_q.delete();
`ifdef POSIT_NORMALIZE_RNE_EN
    add(1'b0, 1'b0, 1'b0, 2, 4'b0001, 1'b0, 8'h60);
    add(1'b0, 1'b0, 1'b0, 2, 4'b0011, 1'b0, 8'h62);
    add(1'b0, 1'b0, 1'b0, 2, 4'b0001, 1'b1, 8'h61);
    add(1'b1, 1'b0, 1'b0, -11, 4'b0000, 1'b0, 8'hFE);
    add(1'b0, 1'b0, 1'b0, 11, 4'b1000, 1'b0, 8'h7F);
`else
    add(1'b0, 1'b0, 1'b0, 2, 4'b0001, 1'b0, 8'h60);
    add(1'b0, 1'b0, 1'b0, 2, 4'b0011, 1'b0, 8'h61);
    add(1'b0, 1'b0, 1'b0, 2, 4'b0001, 1'b1, 8'h60);
    add(1'b1, 1'b0, 1'b0, -11, 4'b0000, 1'b0, 8'hFF);
    add(1'b0, 1'b0, 1'b0, 11, 4'b1000, 1'b0, 8'h7E);
`endif
    run_beats(-1, -1, 40);
    n_cmp++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL round_count: got %0d want 5", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== stim_q[j].exp) begin
        n_fail++; $display("FAIL round_word[%0d]: got 0x%02h want 0x%02h", j, got_q[j], stim_q[j].exp);
      end
    end
  endtask

  task automatic test_saturation;
    stim_q.delete();
    add(1'b0, 1'b0, 1'b0, 12, 4'b0000, 1'b0, 8'h7F);
    add(1'b0, 1'b0, 1'b0, 13, 4'b0101, 1'b0, 8'h7F);
    add(1'b0, 1'b0, 1'b0, -12, 4'b0000, 1'b0, 8'h01);
    add(1'b0, 1'b0, 1'b0, -15, 4'b1111, 1'b1, 8'h01);
    add(1'b1, 1'b0, 1'b0, 15, 4'b0000, 1'b0, 8'h81);
    add(1'b1, 1'b0, 1'b0, -15, 4'b0000, 1'b0, 8'hFF);
    run_beats(-1, -1, 40);
    n_cmp++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL sat_count: got %0d want 6", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== stim_q[j].exp) begin
        n_fail++; $display("FAIL sat_word[%0d]: got 0x%02h want 0x%02h", j, got_q[j], stim_q[j].exp);
      end
    end
  endtask

  task automatic test_specials;
    stim_q.delete();
    add(1'b1, 1'b1, 1'b0, 15, 4'b1111, 1'b1, 8'h80);
    add(1'b0, 1'b1, 1'b1, 3, 4'b0110, 1'b0, 8'h80);
    add(1'b1, 1'b0, 1'b1, -15, 4'b1010, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b1, 3, 4'b0001, 1'b0, 8'h00);
    run_beats(-1, -1, 40);
    n_cmp++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL special_count: got %0d want 4", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== stim_q[j].exp) begin
        n_fail++; $display("FAIL special_word[%0d]: got 0x%02h want 0x%02h", j, got_q[j], stim_q[j].exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] tbl [10];
    tbl = '{8'h40, 8'h50, 8'h60, 8'h68, 8'h70, 8'h74, 8'h78, 8'h7A, 8'h7C, 8'h7D};
    stim_q.delete();
    for (int j = 0; j < 10; j++) add(1'b0, 1'b0, 1'b0, j, 4'b0000, 1'b0, tbl[j]);
    run_beats(4, 7, 80);
    n_cmp++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== stim_q[j].exp) begin
        n_fail++; $display("FAIL bp_word[%0d]: got 0x%02h want 0x%02h", j, got_q[j], stim_q[j].exp);
      end
    end
    n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_in_ready: in_ready high in %0d stalled cycles, want 0", stall_viol); end
    n_cmp++; if (stall_seen !== 4) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 4", stall_seen); end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra words want 0", extra); end
  endtask

  task automatic test_round_trip;
    stim_q.delete();
    for (int w = 0; w < 256; w++) stim_q.push_back(decode(8'(w)));
    run_beats(-1, -1, 400);
    n_cmp++; if (got_q.size() !== 256) begin n_fail++; $display("FAIL rt_count: got %0d want 256", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== stim_q[j].exp) begin
        n_fail++; $display("FAIL rt_word[%0d]: got 0x%02h want 0x%02h", j, got_q[j], stim_q[j].exp);
      end
    end
  endtask

  task automatic test_reset_flight;
    beat_t b;
    int    seen;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      b = '0;
      b.scale = 5'(j);
      apply(b);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flight_pre_valid: got %b want 1", out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_valid: got %b want 0", out_valid); end
    n_cmp++; if (posit_word_o !== 8'h00) begin n_fail++; $display("FAIL flight_word: got 0x%02h want 0x00", posit_word_o); end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flight_leak: got %0d words want 0", seen); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_i = 1'b0; nar_i = 1'b0; zero_i = 1'b0;
    scale_i = 5'sd0; fraction_i = 4'b0000; sticky_i = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_specials;
    test_backpressure;
    test_round_trip;
    test_reset_flight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
